// File: rtl/uart_rx_frombus.sv
// uart_rx_frombus: 8N1 UART receiver with a small byte FIFO, served LSB-first to the on-chip serial bus.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit, a PARITY state and a sticky parity_err output.
//
// state  | meaning
// IDLE   | armed for a start bit (after a framing error, waits for a high line first)
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling N data bits, LSB first
// STOP   | sampling the stop bit
// ACK    | first cycle pushes the byte, then ack held for CLKS_PER_BIT cycles
// PARITY | sampling the even-parity bit (parity build only)
module uart_rx_frombus #(
    parameter int CLKS_PER_BIT = 20,
    parameter int N            = 8,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ext_data_in,
    input  logic                     rd_req,
    output logic                     ack,
    output logic                     ready,
    output logic                     validOut,
    output logic                     DataOut,
    output logic                     rx_busy,
    output logic [2:0]               state_rx,
    output logic                     frame_err,
    output logic                     overrun,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ACK  = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;

    logic [1:0]    sync_q, sync_d;
    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic          push_q, push_d;
    logic          armed_q, armed_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_q, parity_err_d;
    logic          par_wait_q, par_wait_d;
`endif

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] count_q, count_d;
    logic          full;
    logic          pop;
    logic          fifo_push;

    logic          sh_busy_q, sh_busy_d;
    logic [N-1:0]  sh_data_q, sh_data_d;
    logic [BW-1:0] sh_cnt_q, sh_cnt_d;

    assign sync_d    = {sync_q[0], ext_data_in};
    assign rxs       = sync_q[1];
    assign full      = (count_q == FULL_CNT);
    assign ready     = (count_q != '0) && !sh_busy_q;
    assign pop       = rd_req && ready;
    // A push into a full FIFO still lands when the bus pops in the same cycle.
    assign fifo_push = push_q && (!full || pop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        push_d      = 1'b0;
        armed_d     = armed_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        par_wait_d   = par_wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!armed_q) begin
                    armed_d = rxs;
                end else if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_BIT;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {rxs, shreg_q[N-1:1]};
                    cnt_d   = CNT_BIT;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (par_wait_q) begin
                    if (rxs) begin
                        state_d    = S_IDLE;
                        par_wait_d = 1'b0;
                    end
                end else if (cnt_q == '0) begin
                    if (rxs == ^shreg_q) begin
                        state_d = S_STOP;
                        cnt_d   = CNT_BIT;
                    end else begin
                        parity_err_d = 1'b1;
                        par_wait_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = S_ACK;
                        cnt_d   = CNT_ACK;
                        push_d  = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                if (push_q && !fifo_push) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (fifo_push && !pop) begin
            count_d = count_q + FW'(1);
        end else if (!fifo_push && pop) begin
            count_d = count_q - FW'(1);
        end
    end

    always_comb begin
        sh_busy_d = sh_busy_q;
        sh_data_d = sh_data_q;
        sh_cnt_d  = sh_cnt_q;
        if (pop) begin
            sh_busy_d = 1'b1;
            sh_data_d = mem_q[rd_ptr_q];
            sh_cnt_d  = LAST_BIT;
        end else if (sh_busy_q) begin
            sh_data_d = sh_data_q >> 1;
            if (sh_cnt_q == '0) begin
                sh_busy_d = 1'b0;
            end else begin
                sh_cnt_d = sh_cnt_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            armed_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_wait_q   <= 1'b0;
`endif
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sh_busy_q   <= 1'b0;
            sh_data_q   <= '0;
            sh_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            par_wait_q   <= par_wait_d;
`endif
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sh_busy_q   <= sh_busy_d;
            sh_data_q   <= sh_data_d;
            sh_cnt_q    <= sh_cnt_d;
            if (fifo_push) begin
                mem_q[wr_ptr_q] <= shreg_q;
            end
        end
    end

    // The push cycle is the first ACK cycle; ack covers the CLKS_PER_BIT cycles after it.
    assign ack        = (state_q == S_ACK) && (cnt_q != CNT_ACK);
    assign validOut   = sh_busy_q;
    assign DataOut    = sh_busy_q & sh_data_q[0];
    assign rx_busy    = (state_q != S_IDLE);
    assign state_rx   = state_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign fifo_count = count_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frombus.sv
// Bench for uart_rx_frombus: serial frames driven on ext_data_in, bytes read back over the bus,
// compared against a queue-based model of accepted bytes and sticky flags.
module tb_uart_rx_frombus;

    localparam int CPB   = 20;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_data_in;
    logic       rd_req;
    logic       ack, ready, validOut, DataOut, rx_busy, frame_err, overrun;
    logic [2:0] state_rx;
    logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_frombus #(.CLKS_PER_BIT(CPB), .N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_data_in (ext_data_in),
        .rd_req      (rd_req),
        .ack         (ack),
        .ready       (ready),
        .validOut    (validOut),
        .DataOut     (DataOut),
        .rx_busy     (rx_busy),
        .state_rx    (state_rx),
        .frame_err   (frame_err),
        .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .fifo_count  (fifo_count)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: bytes the receiver should hold, sticky flags, expected ack pulses
    logic [7:0] exp_q[$];
    logic       exp_fe = 1'b0;
    logic       exp_ov = 1'b0;
    int         exp_acks = 0;

    int ack_pulses = 0;
    int ack_run    = 0;
    int ack_last   = 0;

    initial forever begin
        @(negedge clk);
        if (ack === 1'b1) begin
            ack_run++;
        end else if (ack_run != 0) begin
            ack_last = ack_run;
            ack_pulses++;
            ack_run = 0;
        end
    end

    initial begin
        #(600000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ext_data_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < N; i++) begin
            ext_data_in = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        ext_data_in = ^b;
        tick(CPB);
`endif
        ext_data_in = stop_bit;
        tick(CPB);
        ext_data_in = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, fifo_count, exp_q.size());
        chk({tag, "_frame_err"}, frame_err, exp_fe);
        chk({tag, "_overrun"}, overrun, exp_ov);
        chk({tag, "_acks"}, ack_pulses, exp_acks);
        chk({tag, "_idle"}, state_rx, 0);
    endtask

    task automatic do_frame(input logic [7:0] b, input logic good, input string tag);
        logic accepted;
        accepted = good && (exp_q.size() < DEPTH);
        send_frame(b, good);
        if (!good) begin
            exp_fe = 1'b1;
        end else if (accepted) begin
            exp_q.push_back(b);
            exp_acks++;
        end else begin
            exp_ov = 1'b1;
        end
        check_status(tag);
        if (accepted) chk({tag, "_ack_len"}, ack_last, CPB);
    endtask

    // rd_req has just been held across one rising edge; gather the N bits that follow
    task automatic shift_collect(output logic [7:0] w);
        int vcnt;
        vcnt = 0;
        w = '0;
        for (int i = 0; i < N; i++) begin
            w[i] = DataOut;
            if (validOut === 1'b1) vcnt++;
            if (i < N - 1) tick(1);
        end
        tick(1);
        chk("valid_len", vcnt, N);
        chk("idle_dataout", {validOut, DataOut}, 0);
    endtask

    task automatic bus_read(output logic [7:0] w);
        int waited;
        waited = 0;
        while (ready !== 1'b1 && waited < 200) begin
            tick(1);
            waited++;
        end
        chk("ready_wait", ready, 1);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        shift_collect(w);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] w, e;
        e = exp_q.pop_front();
        bus_read(w);
        chk(tag, w, e);
        chk({tag, "_count"}, fifo_count, exp_q.size());
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {ack, ready, validOut, DataOut, rx_busy, state_rx, frame_err, overrun, fifo_count}, 0);
    endtask

    task automatic overlap_push_pop();
        int k;
        logic [7:0] w, e;
        k = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (state_rx !== 3'd4 && k < 400) begin
                    tick(1);
                    k++;
                end
                chk("push_seen", state_rx, 4);
                chk("ready_full", {ready, fifo_count}, {1'b1, 3'd4});
                rd_req = 1'b1;
                tick(1);
                rd_req = 1'b0;
                chk("count_stays_full", fifo_count, 4);
                shift_collect(w);
                e = exp_q.pop_front();
                chk("overlap_head", w, e);
            end
        join
        exp_q.push_back(8'h55);
        exp_acks++;
        check_status("overlap");
        chk("overlap_ack_len", ack_last, CPB);
    endtask

    task automatic release_reset();
        ext_data_in = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        exp_q.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        reset       = 1'b1;
        ext_data_in = 1'b1;
        rd_req      = 1'b0;
        tick(3);
        check_all_zero("reset_outs");
        reset = 1'b0;
        tick(3);

        do_frame(8'hA5, 1'b1, "a5");
        read_check("a5_read");

        ext_data_in = 1'b0;
        tick(5);
        ext_data_in = 1'b1;
        tick(3 * CPB);
        check_status("glitch");

        do_frame(8'h3C, 1'b0, "bad_stop");
        do_frame(8'h11, 1'b1, "after_bad");
        read_check("r11");

        for (int i = 1; i <= 5; i++) do_frame(8'(i), 1'b1, "fill");
        overlap_push_pop();
        while (exp_q.size() > 0) read_check("drain");

        do_frame(8'h77, 1'b1, "pre_rst");
        ext_data_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            ext_data_in = 1'(8'hC3 >> i);
            tick(CPB);
        end
        ext_data_in = 1'b0;
        tick(CPB / 2);
        chk("mid_frame_state", state_rx, 2);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid_frame");
        release_reset();

        do_frame(8'h96, 1'b1, "f96");
        do_frame(8'h69, 1'b1, "f69");
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        tick(3);
        chk("mid_shift_valid", validOut, 1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid_shift");
        release_reset();

        do_frame(8'hFF, 1'b1, "fff");
        read_check("rff");

        for (int it = 0; it < 12; it++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            do_frame(b, good, "rand");
            tick($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) read_check("rand_read");
        end
        while (exp_q.size() > 0) read_check("final_drain");
        check_status("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frombus.md
Name: uart_rx_frombus

Overview:
- Receive-side counterpart of the UART transmit path. Deserializes 8N1 frames arriving on the external serial line and returns an ack pulse to the remote transmitter for each accepted byte.
- Buffers received bytes in a small FIFO.
- Serves the bytes to the on-chip serial bus as a read-only slave: each byte is shifted out LSB-first on DataOut with validOut.
- Sits between the external link pin and the bus slave port, mirroring the uart_tx/bus_to_uart pair.

Parameters:
- CLKS_PER_BIT, 20, clk cycles per UART bit; must be even, >= 4.
- N, 8, data bits per frame and bus word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ext_data_in  input  1  external serial line; idles high.
- rd_req  input  1  single-cycle bus read strobe from the slave decoder.
- ack  output  1  to remote transmitter; high for CLKS_PER_BIT cycles per accepted byte.
- ready  output  1  FIFO non-empty and bus shifter idle.
- validOut  output  1  high while DataOut carries a word bit.
- DataOut  output  1  serial bus data, LSB first.
- rx_busy  output  1  receive FSM not in IDLE.
- state_rx  output  3  receive FSM state, debug.
- frame_err  output  1  sticky, set on bad stop bit.
- overrun  output  1  sticky, set when a good frame meets a full FIFO.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset:
- All outputs 0 except state_rx = IDLE (0).
- Synchronizer flops reset to 1 (line idle).
- FIFO empty, counters cleared.
- Asserting reset mid-frame or mid-shift aborts immediately and discards partial data. No ack is issued.

Input sync:
- ext_data_in passes through a 2-FF synchronizer; all sampling uses the synchronized value (rxs). This adds 2 cycles of latency.

Receive FSM, encoded IDLE=0, START=1, DATA=2, STOP=3, ACK=4:
- IDLE: rxs==0 -> START, bit counter cleared.
- START: at counter == CLKS_PER_BIT/2-1, sample rxs.
  - rxs==1 -> IDLE (glitch, no flag).
  - rxs==0 -> DATA, counter cleared.
- DATA: sample rxs every CLKS_PER_BIT cycles, N times. Bits shift into the shift register LSB first.
- STOP: sample at the next CLKS_PER_BIT boundary.
  - rxs==1, FIFO can accept -> push the byte the following cycle, go to ACK.
  - rxs==1, FIFO full -> set overrun, discard, go to IDLE.
  - rxs==0 -> set frame_err, discard, go to IDLE; the FSM waits in IDLE until rxs==1 before re-arming start detection.
- ACK: ack high exactly CLKS_PER_BIT cycles starting the cycle after the push, then IDLE. The sender holds the line idle during this window; a start bit seen during ACK is ignored.

FIFO:
- Circular, with pointers wrapping modulo DEPTH.
- Same-cycle push and pop are both performed; a push into a full FIFO is accepted only if a pop occurs in that cycle.
- fifo_count updates the cycle after the event.

Bus read side:
- ready = (fifo_count != 0) && shifter idle.
- rd_req while ready: pop the head into the shifter. The next cycle starts N cycles of validOut=1, with DataOut = bit 0..N-1 in order.
- ready stays 0 during the shift and returns the cycle after the last bit.
- rd_req while not ready is ignored with no error.
- DataOut = 0 whenever validOut = 0.

Sticky flags:
- frame_err and overrun clear only on reset.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the frame carries an even-parity bit between the data bits and the stop bit; the FSM inserts a PARITY state (encoding 5) sampled at a bit boundary.
  - A parity mismatch sets a sticky parity_err output, discards the byte, gives no ack, and the FSM waits for rxs==1 before returning to IDLE.
  - The parity_err port exists only when the macro is defined.
- Undefined: 8N1 only; no PARITY state, no parity_err port.

Test Plan:
- Single frame 0xA5 at CLKS_PER_BIT=20 -> ack high 20 cycles after the stop sample; fifo_count=1; rd_req -> validOut 8 cycles, DataOut 1,0,1,0,0,1,0,1.
- Start glitch: line low 5 cycles then high -> FSM back to IDLE; no push, no ack, no flags.
- Stop bit driven 0 on byte 0x3C -> frame_err=1, fifo_count unchanged, ack stays 0; the next good frame 0x11 is accepted normally.
- Five frames 0x01..0x05 with no reads (DEPTH=4) -> four acks, overrun=1 after the fifth; reads return 0x01..0x04.
- rd_req in the same cycle as a push with FIFO full -> both performed; fifo_count stays 4; order preserved.
- Reset asserted at data bit 4 of a frame and again mid-shift on the bus -> all outputs 0 immediately, FIFO empty; the following frame 0xFF is received and acked correctly.
